div_sequencer: RTL
==================

# div_sequencer

Controller for the multi-cycle divider in the EX stage. Accepts DIV/DIVU issue from ID/EX, loads the iterative divider datapath, counts its iterations and commits the quotient/remainder to HI/LO. Interlocks the pipeline so dependent MFHI/MFLO and back-to-back divides wait. Independent instructions keep flowing while a divide runs.

## Interface
- ITERS, 32: divider iterations per operation; ≥2.
- CW, 6: iteration-counter width; ≥ clog2(ITERS)+1.

- clk  in  1  pipeline clock
- rst  in  1  reset, synchronous, active-high
- div_req  in  1  DIV/DIVU present in EX (ID/EX Signal)
- div_signed  in  1  1 = DIV, 0 = DIVU; sampled at accept
- divisor  in  32  EX operand B (rfile_rd2)
- mfhilo_req  in  1  MFHI or MFLO present in EX
- flush  in  1  the EX instruction is squashed this cycle
- dp_load  out  1  load operands and sign mode into the divider datapath
- dp_signed  out  1  latched div_signed for the datapath
- dp_step  out  1  perform one divider iteration
- hilo_we  out  1  write divider result into HI/LO
- dz  out  1  divide-by-zero; HI/LO take the DZ values on this write
- stall  out  1  freeze PC, IF/ID and ID/EX; inject a bubble into EX/MEM
- busy  out  1  divide in flight (state ≠ IDLE)

## Operation
- States:
  - IDLE: no divide in flight.
  - RUN: stepping the datapath; cnt counts 0..ITERS-1.
  - WRITE: one cycle, commits the result.
- IDLE → RUN on accept: div_req & !flush & divisor≠0.
  - Same cycle: dp_load=1, dp_signed latched, cnt←0.
- IDLE → WRITE on div_req & !flush & divisor==0.
  - Same cycle: dp_load=1; dz register ←1.
- RUN: dp_step=1 every cycle; cnt increments. When cnt==ITERS-1, next state is WRITE.
- WRITE: hilo_we=1. dz is held from accept: 1 on the zero-divisor path, 0 otherwise. Next state is IDLE.
- DZ result: HI←dividend, LO←32'hFFFF_FFFF. The datapath selects these values when dz=1.
- stall (combinational) = busy & (div_req | mfhilo_req).
  - A stalled DIV is re-presented after the commit and accepted in IDLE.
- flush:
  - Blocks acceptance and stall generation for the EX instruction that cycle.
  - Never aborts an in-flight divide: that divide belongs to an older, committed instruction.
- div_req and mfhilo_req asserted together is illegal upstream. The sequencer prioritises div_req.

## Timing
- All outputs are 0 in reset and in the first cycle after reset.
- Normal latency, accepting at cycle T:
  - dp_load at T.
  - dp_step at T+1 … T+ITERS.
  - hilo_we at T+ITERS+1.
  - HI/LO are readable by MFHI/MFLO from T+ITERS+2.
- DZ latency: dp_load at T, hilo_we with dz=1 at T+1, IDLE at T+2.
- MFHI/MFLO arriving in EX during WRITE is still stalled. It proceeds the next cycle and sees new HI/LO.
- rst mid-RUN or mid-WRITE:
  - Next cycle is IDLE, cnt=0, dz=0.
  - No hilo_we is issued and HI/LO are left untouched.
- Back-to-back divides: the second is accepted at T+ITERS+2 at the earliest. Throughput is 1 per ITERS+2 cycles.
- cnt never exceeds ITERS-1 and does not wrap.

## Structure
- Shared package `div_pkg`:
  - state enum {IDLE, RUN, WRITE};
  - ITERS default constant;
  - DZ_LO constant 32'hFFFF_FFFF.
- Single module with no sub-modules. The counter and FSM are inline, roughly 150 lines.
- The divider datapath and HiLo register stay in EX. EX wires dp_load/dp_step/dp_signed/hilo_we/dz to them.
- The hazard unit ORs `stall` into its existing stall output.

## Test plan
- DIVU 100/7 at T:
  - dp_load at T;
  - dp_step for 32 cycles;
  - hilo_we at T+33 with dz=0;
  - busy low at T+34.
- DIV divisor=0:
  - hilo_we with dz=1 at T+1;
  - no dp_step;
  - busy low at T+2.
- MFHI in EX at T+5 of a running divide:
  - stall=1 from T+5 through T+33;
  - stall=0 at T+34.
- Second DIV at T+2:
  - stall high until T+33;
  - accepted (dp_load) at T+34;
  - its hilo_we at T+67.
- flush with div_req in IDLE: no dp_load, state stays IDLE, stall=0.
- rst at T+10:
  - all outputs 0 at T+11;
  - no hilo_we ever issued for that divide;
  - new DIV accepted at T+12.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and constants for the divide sequencer
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } div_state_e;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] DZ_LO     = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - controls the iterative divider: load, step, commit to HI/LO, interlock
module div_sequencer
  import div_pkg::*;
#(
  parameter int ITERS = DIV_ITERS,
  parameter int CW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req,
  input  logic        div_signed,
  input  logic [31:0] divisor,
  input  logic        mfhilo_req,
  input  logic        flush,
  output logic        dp_load,
  output logic        dp_signed,
  output logic        dp_step,
  output logic        hilo_we,
  output logic        dz,
  output logic        stall,
  output logic        busy
);

  localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

  div_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          dz_q, dz_n;
  logic          signed_q, signed_n;
  // Low for the first cycle after reset so nothing is accepted until the pipe has settled.
  logic          armed;
  logic          accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dz_q     <= 1'b0;
      signed_q <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dz_q     <= dz_n;
      signed_q <= signed_n;
      armed    <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dz_n      = dz_q;
    signed_n  = signed_q;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    hilo_we   = 1'b0;
    dp_signed = 1'b0;
    dz        = 1'b0;
    busy      = 1'b0;
    stall     = 1'b0;
    accept    = armed & div_req & ~flush;

    case (state)
      IDLE: begin
        if (accept) begin
          dp_load  = 1'b1;
          signed_n = div_signed;
          cnt_n    = '0;
          // A zero divisor skips the iterations and commits the fixed DZ result directly.
          if (divisor == '0) begin
            dz_n    = 1'b1;
            state_n = WRITE;
          end else begin
            dz_n    = 1'b0;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        dp_step = 1'b1;
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = WRITE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WRITE: begin
        hilo_we = 1'b1;
        dz_n    = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (rst) begin
      dp_load = 1'b0;
      dp_step = 1'b0;
      hilo_we = 1'b0;
    end else begin
      busy      = (state != IDLE);
      dz        = dz_q;
      dp_signed = dp_load ? div_signed : (busy & signed_q);
      // A squashed EX instruction never waits on the divider.
      stall     = busy & (div_req | mfhilo_req) & ~flush;
    end
  end

endmodule
